rgb_scanout: RTL and testbench
==============================

# rgb_scanout

Parametrised LCD/RGB-panel scan-out engine that generates horizontal/vertical timing, fetches pixels from a framebuffer with a configurable read latency, and drives latency-aligned 24-bit RGB with sync and data-enable. It sits between the framebuffer memory port and the parallel RGB panel pins. It adds programmable sync polarity, four selectable pixel formats latched per frame, bit-replicating colour expansion, an enable control, and frame/line markers.

## Interface
- H_ACTIVE, 800, active pixels per line
- H_FP / H_SYNC / H_BP, 40 / 48 / 40, horizontal front porch / sync / back porch in pixels
- V_ACTIVE, 480, active lines per frame
- V_FP / V_SYNC / V_BP, 13 / 3 / 29, vertical front porch / sync / back porch in lines
- HS_POL / VS_POL, 0 / 0, sync active level (0 = active-low, 1 = active-high)
- FB_LATENCY, 2, cycles from fb_addr/fb_rd output to pixel_data valid; legal range 1..8
- ADDR_W, 19, framebuffer address width; must hold H_ACTIVE*V_ACTIVE-1
- CNT_W, 12, h/v counter width
- clk  in  1  pixel clock
- rst  in  1  reset: synchronous, active-high
- en  in  1  scan enable; low holds timing at (0,0) and blanks outputs
- fmt  in  2  pixel format: 0 RGB565, 1 RGB555, 2 GRAY8, 3 RGB332
- fb_addr  out  ADDR_W  framebuffer read address
- fb_rd  out  1  read strobe, high for each active-pixel fetch
- pixel_data  in  16  framebuffer read data, valid FB_LATENCY cycles after fb_addr/fb_rd
- hsync / vsync  out  1  sync outputs at configured polarity
- de  out  1  data enable
- red / green / blue  out  8 each  expanded colour, 0 when de low
- frame_start  out  1  one-cycle pulse with first output pixel of a frame
- line_start  out  1  one-cycle pulse with first output pixel of each active line

## Operation
- Stage 0: h_cnt counts 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP); wrap increments v_cnt 0..V_TOTAL-1, which wraps to 0.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE. Sync active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync likewise on v_cnt.
- Address: linear counter, no multiplier. Cleared at (0,0), incremented after each active pixel; fb_rd high exactly for active positions.
- fmt sampled only when stage 0 is at (0,0) with en high; changes mid-frame take effect next frame.
- Expansion (bit replication): RGB565 r5→{r5,r5[4:2]}, g6→{g6,g6[5:4]}, b5 as r; RGB555 uses [14:10],[9:5],[4:0], each 5→8 as r, bit 15 ignored; GRAY8 pixel_data[7:0] to all three; RGB332 low byte, r3/g3→{x,x,x[2:1]}, b2→{b,b,b,b}.
- de, sync, line/frame markers travel a shift register matched to the data path.
- en low: next cycle stage 0 forced to (0,0), address cleared, fb_rd low; bubbles entering the pipeline carry de=0 and inactive sync. On en rising, scan restarts at a new frame (fresh fmt sample, frame_start issued).
- rst: all outputs reset: fb_addr 0, fb_rd 0, de 0, RGB 0, frame_start/line_start 0, hsync = !HS_POL, vsync = !VS_POL; pipeline cleared. Reset mid-frame discards in-flight pixels.

## Timing
- fb_addr/fb_rd registered: valid 1 cycle after stage-0 position.
- pixel_data captured FB_LATENCY cycles later; RGB registered one more cycle.
- Total alignment L = FB_LATENCY + 2: hsync, vsync, de, RGB, markers for position (h,v) all appear L cycles after stage 0 held (h,v).
- Line period H_TOTAL cycles, frame period H_TOTAL*V_TOTAL cycles, no gaps.
- No backpressure: framebuffer must return data at fixed FB_LATENCY.

## Configuration
- RGB_SCANOUT_PATTERN_EN defined: adds input pattern_sel (1 bit). When high, the colour source is 8 internal vertical bars of width H_ACTIVE/8 (white, yellow, cyan, green, magenta, red, blue, black; last bar absorbs the remainder), aligned to the same L latency, and fb_rd held 0; fb_addr still advances. Sampled per frame like fmt.
- Undefined: no pattern_sel port, pixel source is always pixel_data.

## Structure
- Package rgb_scanout_pkg: fmt encodings (FMT_RGB565/RGB555/GRAY8/RGB332), colour-bar RGB888 constants, FB_LATENCY bounds.
- Sub-module rgb_expand: combinational format→RGB888 expansion, instantiated once before the output register.

## Test plan
- Defaults, rst then en=1: hsync low 48 cycles per 928-cycle line, vsync low 3 lines per 525-line frame, first de and frame_start at cycle L=4 after en.
- RGB565: 0xF800 → FF/00/00; 0x8410 → 84/82/84; 0x07E0 → 00/FF/00.
- fmt=0→2 mid-frame: no change until next frame; then pixel_data 0x005A → 5A/5A/5A.
- FB_LATENCY=4, HS_POL=1: hsync active-high, de at cycle 6; fb_addr reaches 383999 on last active pixel, 0 at next frame.
- en dropped mid-line: within L cycles de=0, sync inactive; re-enable → fb_addr 0, frame_start after L cycles.
- With RGB_SCANOUT_PATTERN_EN, pattern_sel=1: pixel 0 FFFFFF, pixel 100 FFFF00, pixel 799 000000; fb_rd stays 0.

Source files
------------

// File: rtl/rgb_scanout_pkg.sv
// rgb_scanout_pkg: pixel formats, colour-bar constants and pipeline tap type for rgb_scanout.
package rgb_scanout_pkg;
    typedef enum logic [1:0] {FMT_RGB565, FMT_RGB555, FMT_GRAY8, FMT_RGB332} fmt_t;
    localparam int FB_LATENCY_MIN = 1;
    localparam int FB_LATENCY_MAX = 8;
    localparam logic [23:0] WHITE = 24'hFFFFFF, YELLOW = 24'hFFFF00, CYAN = 24'h00FFFF, GREEN = 24'h00FF00;
    localparam logic [23:0] MAGENTA = 24'hFF00FF, RED = 24'hFF0000, BLUE = 24'h0000FF, BLACK = 24'h000000;
    localparam logic [7:0][23:0] BARS = {BLACK, BLUE, RED, MAGENTA, GREEN, CYAN, YELLOW, WHITE};
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic fs;
        logic ls;
        logic pat;
        fmt_t fmt;
        logic [2:0] bar;
    } tap_t;
endpackage

// File: rtl/rgb_scanout_if.sv
// rgb_scanout_if: framebuffer read port plus parallel RGB panel pins.
interface rgb_scanout_if #(parameter int ADDR_W = 19);
    logic [ADDR_W-1:0] fb_addr;
    logic fb_rd;
    logic [15:0] pixel_data;
    logic hsync, vsync, de;
    logic [7:0] red, green, blue;
    logic frame_start, line_start;
    modport master(output fb_addr, fb_rd, hsync, vsync, de, red, green, blue, frame_start, line_start,
                   input pixel_data);
    modport slave(input fb_addr, fb_rd, hsync, vsync, de, red, green, blue, frame_start, line_start,
                  output pixel_data);
endinterface

// File: rtl/rgb_expand.sv
// rgb_expand: bit-replicating expansion of a 16-bit framebuffer word to RGB888.
module rgb_expand
    import rgb_scanout_pkg::*;
(
    input logic [15:0] d,
    input fmt_t fmt,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b
);
    always_comb begin
        r = fmt == FMT_RGB565 ? {d[15:11], d[15:13]} : fmt == FMT_RGB555 ? {d[14:10], d[14:12]} :
            fmt == FMT_GRAY8 ? d[7:0] : {d[7:5], d[7:5], d[7:6]};
        g = fmt == FMT_RGB565 ? {d[10:5], d[10:9]} : fmt == FMT_RGB555 ? {d[9:5], d[9:7]} :
            fmt == FMT_GRAY8 ? d[7:0] : {d[4:2], d[4:2], d[4:3]};
        b = fmt == FMT_GRAY8 ? d[7:0] : fmt == FMT_RGB332 ? {4{d[1:0]}} : {d[4:0], d[4:2]};
    end
endmodule

// File: rtl/rgb_scanout.sv
// rgb_scanout: panel timing, framebuffer fetch and latency-aligned RGB/sync/de output.
// Define RGB_SCANOUT_PATTERN_EN to add the pattern_sel colour-bar source.
module rgb_scanout
    import rgb_scanout_pkg::*;
#(
    parameter int H_ACTIVE = 800,
    parameter int H_FP = 40,
    parameter int H_SYNC = 48,
    parameter int H_BP = 40,
    parameter int V_ACTIVE = 480,
    parameter int V_FP = 13,
    parameter int V_SYNC = 3,
    parameter int V_BP = 29,
    parameter int HS_POL = 0,
    parameter int VS_POL = 0,
    parameter int FB_LATENCY = 2,
    parameter int ADDR_W = 19,
    parameter int CNT_W = 12
) (
    input logic clk,
    input logic rst,
    input logic en,
    input logic [1:0] fmt,
`ifdef RGB_SCANOUT_PATTERN_EN
    input logic pattern_sel,
`endif
    rgb_scanout_if.master bus
);
    // Out-of-range latencies are pinned to the nearest legal value.
    localparam int FBL = FB_LATENCY < FB_LATENCY_MIN ? FB_LATENCY_MIN :
                         FB_LATENCY > FB_LATENCY_MAX ? FB_LATENCY_MAX : FB_LATENCY;
    localparam int L = FBL + 2;
    localparam logic [CNT_W-1:0] HA = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS0 = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS1 = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] VA = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS0 = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS1 = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACTIVE / 8 - 1);
    localparam logic HS_ACT = HS_POL != 0;
    localparam logic VS_ACT = VS_POL != 0;

    logic [CNT_W-1:0] h_cnt, v_cnt, bar_x;
    logic [2:0] bar;
    logic [ADDR_W-1:0] addr, addr_cur;
    fmt_t fmt_q, fmt_cur;
    logic pat_q, pat_cur, origin, active, h_end;
    tap_t tap;
    tap_t sr [L];
    logic [7:0] er, eg, eb;
    logic [23:0] px, rgb;

    always_comb begin
        origin = h_cnt == '0 && v_cnt == '0;
        active = h_cnt < HA && v_cnt < VA;
        h_end = h_cnt == H_LAST;
        addr_cur = origin ? '0 : addr;
        fmt_cur = origin && en ? fmt_t'(fmt) : fmt_q;
`ifdef RGB_SCANOUT_PATTERN_EN
        pat_cur = origin && en ? pattern_sel : pat_q;
`else
        pat_cur = pat_q;
`endif
        tap = '{de: en && active, hs: en && h_cnt >= HS0 && h_cnt < HS1,
                vs: en && v_cnt >= VS0 && v_cnt < VS1, fs: en && origin,
                ls: en && h_cnt == '0 && v_cnt < VA, pat: pat_cur, fmt: fmt_cur, bar: bar};
        px = sr[FBL].pat ? BARS[sr[FBL].bar] : {er, eg, eb};
    end

    rgb_expand u_expand (.d(bus.pixel_data), .fmt(sr[FBL].fmt), .r(er), .g(eg), .b(eb));

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
            bar <= '0;
            bar_x <= '0;
            addr <= '0;
            fmt_q <= FMT_RGB565;
            pat_q <= 1'b0;
            bus.fb_addr <= '0;
            bus.fb_rd <= 1'b0;
            rgb <= '0;
            for (int i = 0; i < L; i++) sr[i] <= '0;
        end else begin
            fmt_q <= fmt_cur;
            pat_q <= pat_cur;
            sr[0] <= tap;
            for (int i = 1; i < L; i++) sr[i] <= sr[i-1];
            // sr[FBL] is the tap whose fetch returns on pixel_data this cycle.
            rgb <= sr[FBL].de ? px : '0;
            if (!en) begin
                h_cnt <= '0;
                v_cnt <= '0;
                bar <= '0;
                bar_x <= '0;
                addr <= '0;
                bus.fb_addr <= '0;
                bus.fb_rd <= 1'b0;
            end else begin
                h_cnt <= h_end ? '0 : h_cnt + CNT_W'(1);
                if (h_end) v_cnt <= v_cnt == V_LAST ? '0 : v_cnt + CNT_W'(1);
                addr <= active ? addr_cur + ADDR_W'(1) : addr_cur;
                bus.fb_addr <= addr_cur;
                bus.fb_rd <= active && !pat_cur;
                if (h_end) begin
                    bar <= '0;
                    bar_x <= '0;
                end else if (bar_x == BAR_LAST && bar != 3'd7) begin
                    bar <= bar + 3'd1;
                    bar_x <= '0;
                end else begin
                    bar_x <= bar_x + CNT_W'(1);
                end
            end
        end
    end

    assign bus.hsync = sr[L-1].hs ? HS_ACT : !HS_ACT;
    assign bus.vsync = sr[L-1].vs ? VS_ACT : !VS_ACT;
    assign bus.de = sr[L-1].de;
    assign bus.frame_start = sr[L-1].fs;
    assign bus.line_start = sr[L-1].ls;
    assign {bus.red, bus.green, bus.blue} = rgb;
endmodule

// File: tb/tb_rgb_scanout.sv
// tb_rgb_scanout: directed checks of rgb_scanout at default and reduced geometries.
module tb_rgb_scanout;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic [1:0] fmt = 2'd0;
`ifdef RGB_SCANOUT_PATTERN_EN
    logic pattern_sel = 1'b0;
`endif
    int n_run = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0] fmt;
        logic [15:0] data;
        logic [23:0] rgb;
    } vec_t;
    vec_t vt [12];

    logic [15:0] mem [1024];
    logic [18:0] a0 [8];
    logic [18:0] a1 [8];
    logic [18:0] a2 [8];

    always #5 clk = ~clk;

    rgb_scanout_if #(.ADDR_W(19)) b0 ();
    rgb_scanout_if #(.ADDR_W(19)) b1 ();
    rgb_scanout_if #(.ADDR_W(19)) b2 ();

    rgb_scanout d0 (
        .clk(clk), .rst(rst), .en(en), .fmt(fmt),
`ifdef RGB_SCANOUT_PATTERN_EN
        .pattern_sel(pattern_sel),
`endif
        .bus(b0)
    );
    rgb_scanout #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                  .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) d1 (
        .clk(clk), .rst(rst), .en(en), .fmt(fmt),
`ifdef RGB_SCANOUT_PATTERN_EN
        .pattern_sel(pattern_sel),
`endif
        .bus(b1)
    );
    rgb_scanout #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                  .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                  .FB_LATENCY(4), .HS_POL(1), .VS_POL(1)) d2 (
        .clk(clk), .rst(rst), .en(en), .fmt(fmt),
`ifdef RGB_SCANOUT_PATTERN_EN
        .pattern_sel(pattern_sel),
`endif
        .bus(b2)
    );

    // Fixed-latency framebuffer: a[k] holds fb_addr from k+1 cycles ago.
    always @(posedge clk) begin
        a0[0] <= b0.fb_addr;
        for (int i = 1; i < 8; i++) a0[i] <= a0[i-1];
    end
    always @(posedge clk) begin
        a1[0] <= b1.fb_addr;
        for (int j = 1; j < 8; j++) a1[j] <= a1[j-1];
    end
    always @(posedge clk) begin
        a2[0] <= b2.fb_addr;
        for (int k = 1; k < 8; k++) a2[k] <= a2[k-1];
    end
    assign b0.pixel_data = mem[a0[1][9:0]];
    assign b1.pixel_data = mem[a1[1][9:0]];
    assign b2.pixel_data = mem[a2[3][9:0]];

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic restart();
        en = 1'b0;
        step(10);
        en = 1'b1;
    endtask

    int first0, fs0, hsf0, hs0, hs1, vs1, de1, fs1, ls1, first2, hs2, vs2, rd0;
    logic [18:0] last2, addr193;
    logic rd193;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{2'd0, 16'hF800, 24'hFF0000};
        vt[1] = '{2'd0, 16'h8410, 24'h848284};
        vt[2] = '{2'd0, 16'h07E0, 24'h00FF00};
        vt[3] = '{2'd1, 16'h7C00, 24'hFF0000};
        vt[4] = '{2'd1, 16'h83E0, 24'h00FF00};
        vt[5] = '{2'd1, 16'h4210, 24'h848484};
        vt[6] = '{2'd2, 16'h005A, 24'h5A5A5A};
        vt[7] = '{2'd2, 16'hFF33, 24'h333333};
        vt[8] = '{2'd3, 16'h00E0, 24'hFF0000};
        vt[9] = '{2'd3, 16'h001C, 24'h00FF00};
        vt[10] = '{2'd3, 16'h0003, 24'h0000FF};
        vt[11] = '{2'd3, 16'hAB92, 24'h9292AA};
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        step(3);
        chk("rst_fb_addr", 32'(b1.fb_addr), 0);
        chk("rst_fb_rd", 32'(b1.fb_rd), 0);
        chk("rst_de", 32'(b1.de), 0);
        chk("rst_rgb", {8'h0, b1.red, b1.green, b1.blue}, 0);
        chk("rst_hsync_lowpol", 32'(b1.hsync), 1);
        chk("rst_vsync_lowpol", 32'(b1.vsync), 1);
        chk("rst_markers", {b1.frame_start, b1.line_start}, 0);
        chk("rst_hsync_highpol", 32'(b2.hsync), 0);
        chk("rst_vsync_highpol", 32'(b2.vsync), 0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            fmt = vt[i].fmt;
            mem[0] = vt[i].data;
            restart();
            step(3);
            chk($sformatf("vec%0d_de_early", i), 32'(b1.de), 0);
            step(1);
            chk($sformatf("vec%0d_de", i), 32'(b1.de), 1);
            chk($sformatf("vec%0d_rgb", i), {8'h0, b1.red, b1.green, b1.blue}, {8'h0, vt[i].rgb});
        end

        fmt = 2'd0;
        {first0, fs0, hsf0, hs0, hs1, vs1, de1, fs1, ls1, first2, hs2, vs2} = '0;
        last2 = '0;
        restart();
        for (int c = 1; c <= 940; c++) begin
            step(1);
            if (b0.de && first0 == 0) first0 = c;
            if (b0.frame_start && fs0 == 0) fs0 = c;
            if (!b0.hsync && hsf0 == 0) hsf0 = c;
            if (c >= 4 && c < 932 && !b0.hsync) hs0++;
            if (c >= 4 && c < 196) begin
                hs1 += int'(!b1.hsync);
                vs1 += int'(!b1.vsync);
                de1 += int'(b1.de);
                fs1 += int'(b1.frame_start);
                ls1 += int'(b1.line_start);
            end
            if (b2.de && first2 == 0) first2 = c;
            if (c >= 6 && c < 198) begin
                hs2 += int'(b2.hsync);
                vs2 += int'(b2.vsync);
            end
            if (c <= 192 && b2.fb_rd) last2 = b2.fb_addr;
            if (c == 193) begin
                addr193 = b2.fb_addr;
                rd193 = b2.fb_rd;
            end
        end
        chk("def_first_de", first0, 4);
        chk("def_frame_start", fs0, 4);
        chk("def_first_hsync", hsf0, 844);
        chk("def_hsync_low_per_line", hs0, 48);
        chk("small_hsync_low_per_frame", hs1, 24);
        chk("small_vsync_low_per_frame", vs1, 48);
        chk("small_de_per_frame", de1, 64);
        chk("small_frame_starts", fs1, 1);
        chk("small_line_starts", ls1, 4);
        chk("lat4_first_de", first2, 6);
        chk("lat4_hsync_high_per_frame", hs2, 24);
        chk("lat4_vsync_high_per_frame", vs2, 48);
        chk("lat4_last_addr", 32'(last2), 63);
        chk("lat4_next_frame_addr", 32'(addr193), 0);
        chk("lat4_next_frame_rd", 32'(rd193), 1);

        for (int i = 0; i < 1024; i++) mem[i] = 16'h005A;
        fmt = 2'd0;
        restart();
        step(10);
        fmt = 2'd2;
        step(22);
        chk("fmtchg_same_frame_de", 32'(b1.de), 1);
        chk("fmtchg_same_frame_rgb", {8'h0, b1.red, b1.green, b1.blue}, 32'h0008D6);
        step(164);
        chk("fmtchg_next_frame_fs", 32'(b1.frame_start), 1);
        chk("fmtchg_next_frame_rgb", {8'h0, b1.red, b1.green, b1.blue}, 32'h5A5A5A);

        restart();
        step(10);
        chk("endrop_pre_de", 32'(b1.de), 1);
        en = 1'b0;
        step(1);
        chk("endrop_fb_rd", 32'(b1.fb_rd), 0);
        chk("endrop_fb_addr", 32'(b1.fb_addr), 0);
        step(3);
        chk("endrop_de", 32'(b1.de), 0);
        chk("endrop_sync", {b1.hsync, b1.vsync}, 3);
        chk("endrop_rgb", {8'h0, b1.red, b1.green, b1.blue}, 0);
        step(6);
        en = 1'b1;
        step(1);
        chk("reen_fb_addr", 32'(b1.fb_addr), 0);
        chk("reen_fb_rd", 32'(b1.fb_rd), 1);
        step(3);
        chk("reen_frame_start", 32'(b1.frame_start), 1);
        chk("reen_de", 32'(b1.de), 1);

        step(4);
        rst = 1'b1;
        step(1);
        chk("midrst_de", 32'(b1.de), 0);
        chk("midrst_rgb", {8'h0, b1.red, b1.green, b1.blue}, 0);
        chk("midrst_fb", {b1.fb_rd, b1.fb_addr}, 0);
        rst = 1'b0;

`ifdef RGB_SCANOUT_PATTERN_EN
        pattern_sel = 1'b1;
        rd0 = 0;
        restart();
        for (int c = 1; c <= 804; c++) begin
            step(1);
            rd0 += int'(b0.fb_rd);
            if (c == 4) chk("pat_px0", {8'h0, b0.red, b0.green, b0.blue}, 32'hFFFFFF);
            if (c == 104) chk("pat_px100", {8'h0, b0.red, b0.green, b0.blue}, 32'hFFFF00);
            if (c == 354) chk("pat_px350", {8'h0, b0.red, b0.green, b0.blue}, 32'h00FF00);
            if (c == 703) chk("pat_px699", {8'h0, b0.red, b0.green, b0.blue}, 32'h0000FF);
            if (c == 803) begin
                chk("pat_px799_de", 32'(b0.de), 1);
                chk("pat_px799", {8'h0, b0.red, b0.green, b0.blue}, 32'h000000);
            end
        end
        chk("pat_fb_rd_count", rd0, 0);
        pattern_sel = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
